muldiv_unit: RTL

Iterative 16-bit multiply/divide execution unit that sits directly downstream of the register file read ports and upstream of its write port. It latches the two read operands `rX`/`rY` and a destination address, runs a 16-iteration shift-add (multiply) or restoring shift-subtract (divide) sequence, and presents the result with the destination address as a one-cycle write request into the register file write port. It honours the same `clk_en` stall as the register file.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/muldiv_unit.sv | 115 +++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the multiply/divide unit's
// operation and state encodings.
package cpu_pkg;

    localparam int DTYPE    = 16;
    localparam int ADDR_LEN = 3;

    typedef enum logic [1:0] {
        MUL  = 2'd0,
        MULH = 2'd1,
        DIV  = 2'd2,
        REM  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 16-bit unsigned multiply/divide unit. Sixteen shift-add or
// restoring shift-subtract steps share one 33-bit shift register.
module muldiv_unit
    import cpu_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                clk_en,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [DTYPE-1:0]    rX,
    input  logic [DTYPE-1:0]    rY,
    input  logic [ADDR_LEN-1:0] rZ_address_in,
    output logic                busy,
    output logic                done,
    output logic [DTYPE-1:0]    rZ,
    output logic [ADDR_LEN-1:0] rZ_address
);

    localparam int ACC_W = 2 * DTYPE + 1;

    muldiv_state_t       state_q, state_n;
    muldiv_op_t          op_q;
    logic [3:0]          cnt_q;
    logic [DTYPE-1:0]    b_q;
    logic [ADDR_LEN-1:0] addr_q;
    logic [ACC_W-1:0]    acc_q, acc_n;
    logic                accept;
    logic                last_iter;
    logic [DTYPE:0]      mul_sum;
    logic [DTYPE:0]      div_sh;
    logic [DTYPE:0]      div_diff;
    logic [DTYPE-1:0]    result;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else if (clk_en) begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        accept    = 1'b0;
        last_iter = 1'b0;
        case (state_q)
            IDLE: begin
                accept = start;
                if (start) state_n = RUN;
            end
            RUN: begin
                last_iter = (cnt_q == 4'd15);
                if (cnt_q == 4'd15) state_n = DONE;
            end
            DONE: begin
                accept  = start;
                state_n = start ? RUN : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Multiply: acc = {partial high, multiplier}, shifted right each step.
    // Divide: acc = {17-bit partial remainder, dividend/quotient}, shifted left.
    // A zero divisor never borrows, so the quotient fills with ones and the
    // dividend shifts through unchanged into the remainder.
    always_comb begin
        mul_sum  = acc_q[ACC_W-1:DTYPE] + (acc_q[0] ? {1'b0, b_q} : {(DTYPE+1){1'b0}});
        div_sh   = acc_q[2*DTYPE-1:DTYPE-1];
        div_diff = div_sh - {1'b0, b_q};
        if (op_q == DIV || op_q == REM) begin
            if (div_diff[DTYPE])
                acc_n = {div_sh, acc_q[DTYPE-2:0], 1'b0};
            else
                acc_n = {div_diff, acc_q[DTYPE-2:0], 1'b1};
        end else begin
            acc_n = {1'b0, mul_sum, acc_q[DTYPE-1:1]};
        end
        result = (op_q == MULH || op_q == REM) ? acc_n[2*DTYPE-1:DTYPE]
                                               : acc_n[DTYPE-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            rZ         <= '0;
            rZ_address <= '0;
            op_q       <= MUL;
            cnt_q      <= '0;
            b_q        <= '0;
            addr_q     <= '0;
            acc_q      <= '0;
        end else if (clk_en) begin
            busy <= (state_n == RUN);
            done <= (state_n == DONE);
            if (accept) begin
                op_q   <= muldiv_op_t'(op);
                b_q    <= rY;
                addr_q <= rZ_address_in;
                acc_q  <= {{(DTYPE+1){1'b0}}, rX};
                cnt_q  <= '0;
            end else if (state_q == RUN) begin
                acc_q <= acc_n;
                cnt_q <= cnt_q + 4'd1;
                if (last_iter) begin
                    rZ         <= result;
                    rZ_address <= addr_q;
                end
            end
        end
    end

endmodule
